id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath; sits directly upstream of the EX-stage RegDst mux and feeds it the rt, rd and alternate destination fields plus the 2-bit RegDst select.
- Also contains the load-use hazard detector, because it already holds the in-flight EX destination.
- Supports external stall (hold), branch flush, automatic bubble insertion, and a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg_pkg.sv | 34 +++
 rtl/id_ex_pipe_reg_load_use_detect.sv | 57 +++++
 rtl/id_ex_pipe_reg.sv | 140 ++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX register and the EX-stage destination mux.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the RegDst select encoding, the fixed register numbers used by the
// destination decode, and the bit layout of the opaque control bundle that
// travels from ID to EX. RegDst, RegWrite and MemRead are not part of the
// bundle; they have dedicated ports.
package id_ex_pipe_reg_pkg;

  // RegDst select encoding, shared with the EX destination mux.
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_RA  = 2'd2;
  localparam logic [1:0] REGDST_ALT = 2'd3;

  // Architectural register numbers.
  localparam int REG_RA   = 31;  // link register written by jal/jalr
  localparam int REG_ZERO = 0;   // hard-wired zero, never a real destination

  // Control bundle layout (default 12-bit bundle).
  localparam int CTRL_W_DEF       = 12;
  localparam int CTRL_ALUOP_LSB   = 0;   // ALU operation select
  localparam int CTRL_ALUOP_W     = 4;
  localparam int CTRL_ALUSRC_BIT  = 4;   // 1: second operand is immediate
  localparam int CTRL_SHSRC_BIT   = 5;   // 1: shift amount from register
  localparam int CTRL_MEMWR_BIT   = 6;   // store
  localparam int CTRL_MEMSZ_LSB   = 7;   // access size: byte/half/word
  localparam int CTRL_MEMSZ_W     = 2;
  localparam int CTRL_MEMSGN_BIT  = 9;   // sign-extend loaded data
  localparam int CTRL_MEM2REG_BIT = 10;  // writeback selects memory data
  localparam int CTRL_LINK_BIT    = 11;  // writeback selects PC+8

endpackage

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard detector: decodes the EX destination and flags a stall.
// Latency: purely combinational, zero cycles.
// Backpressure: output is the stall request itself; suppressed while ExtStall holds the pipe.
//
// Ports:
//   ExtStall                 downstream hold; a held pipe cannot create a new hazard
//   exValid, exMemRead       EX-stage instruction is a real load
//   exRegDst, exRt, exRd,    EX destination select and candidate fields
//   exDstAlt
//   idValid, idRs, idRt,     ID-stage instruction and its source fields
//   idUsesRt
//   HazardStall              hold PC and IF/ID, insert one bubble into EX
module load_use_detect
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ExtStall,
  input  logic             exValid,
  input  logic             exMemRead,
  input  logic [1:0]       exRegDst,
  input  logic [REG_W-1:0] exRt,
  input  logic [REG_W-1:0] exRd,
  input  logic [REG_W-1:0] exDstAlt,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRt,
  output logic             HazardStall
);

  logic [REG_W-1:0] exDest;
  logic             loadInFlight;
  logic             srcMatch;

  // Same decode as the EX-stage RegDst mux, so the detector compares against
  // exactly the register the load will write.
  always_comb begin
    exDest = exRt;
    case (exRegDst)
      REGDST_RT: exDest = exRt;
      REGDST_RD: exDest = exRd;
      REGDST_RA: exDest = REG_W'(REG_RA);
      default:   exDest = exDstAlt;
    endcase
  end

  // A load targeting r0 produces nothing anyone can consume.
  assign loadInFlight = exValid & exMemRead & (exDest != REG_W'(REG_ZERO));

  // rt only matters when the ID instruction actually reads it (e.g. not for
  // I-type ALU ops where rt is the destination).
  assign srcMatch = (exDest == idRs) | (idUsesRt & (exDest == idRt));

  assign HazardStall = ~ExtStall & loadInFlight & idValid & srcMatch;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion and bubble counter.
// Latency: one cycle from id_* inputs to ex_* outputs; HazardStall is combinational.
// Backpressure: ExtStall freezes all state; HazardStall holds upstream for one bubble; Flush squashes.
//
// Ports:
//   Clk, Rst_n             pipeline clock, asynchronous active-low reset
//   Flush                  branch/jump taken: load a bubble (beats ExtStall)
//   ExtStall               downstream multicycle stall: hold everything
//   id_*                   decoded ID-stage instruction fields, control and operands
//   HazardStall            load-use stall request to PC and IF/ID
//   ex_*                   registered copy of the ID-stage instruction for EX
//   BubbleCount            saturating count of load-use bubbles inserted
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              ExtStall,
  input  logic              id_Valid,
  input  logic [REG_W-1:0]  id_Rs,
  input  logic [REG_W-1:0]  id_Rt,
  input  logic [REG_W-1:0]  id_Rd,
  input  logic [REG_W-1:0]  id_DstAlt,
  input  logic              id_UsesRt,
  input  logic [1:0]        id_RegDst,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic [CTRL_W-1:0] id_Ctrl,
  input  logic [DATA_W-1:0] id_RsData,
  input  logic [DATA_W-1:0] id_RtData,
  input  logic [DATA_W-1:0] id_Imm,
  output logic              HazardStall,
  output logic              ex_Valid,
  output logic [REG_W-1:0]  ex_Rs,
  output logic [REG_W-1:0]  ex_Rt,
  output logic [REG_W-1:0]  ex_Rd,
  output logic [REG_W-1:0]  ex_DstAlt,
  output logic [1:0]        ex_RegDst,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic [CTRL_W-1:0] ex_Ctrl,
  output logic [DATA_W-1:0] ex_RsData,
  output logic [DATA_W-1:0] ex_RtData,
  output logic [DATA_W-1:0] ex_Imm,
  output logic [CNT_W-1:0]  BubbleCount
);

  // The detector sees only registered EX state plus ID register fields, so
  // there is no path from id_* operand data to any output.
  load_use_detect #(
    .REG_W (REG_W)
  ) uDetect (
    .ExtStall    (ExtStall),
    .exValid     (ex_Valid),
    .exMemRead   (ex_MemRead),
    .exRegDst    (ex_RegDst),
    .exRt        (ex_Rt),
    .exRd        (ex_Rd),
    .exDstAlt    (ex_DstAlt),
    .idValid     (id_Valid),
    .idRs        (id_Rs),
    .idRt        (id_Rt),
    .idUsesRt    (id_UsesRt),
    .HazardStall (HazardStall)
  );

  logic loadBubble;
  logic capture;
  logic countBubble;

  // Edge action, highest priority first: Flush, ExtStall hold, hazard bubble,
  // normal capture. HazardStall is already low under ExtStall, so only Flush
  // needs to mask it for the counter.
  assign loadBubble  = Flush | (~ExtStall & HazardStall);
  assign capture     = ~Flush & ~ExtStall & ~HazardStall;
  assign countBubble = ~Flush & HazardStall;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_Valid    <= 1'b0;
      ex_Rs       <= '0;
      ex_Rt       <= '0;
      ex_Rd       <= '0;
      ex_DstAlt   <= '0;
      ex_RegDst   <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_Ctrl     <= '0;
      ex_RsData   <= '0;
      ex_RtData   <= '0;
      ex_Imm      <= '0;
    end else if (loadBubble) begin
      // Bubble clears everything, not just the side-effect controls, to keep
      // waveforms deterministic.
      ex_Valid    <= 1'b0;
      ex_Rs       <= '0;
      ex_Rt       <= '0;
      ex_Rd       <= '0;
      ex_DstAlt   <= '0;
      ex_RegDst   <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_Ctrl     <= '0;
      ex_RsData   <= '0;
      ex_RtData   <= '0;
      ex_Imm      <= '0;
    end else if (capture) begin
      // Fields are captured even when id_Valid is low; consumers gate on
      // ex_Valid.
      ex_Valid    <= id_Valid;
      ex_Rs       <= id_Rs;
      ex_Rt       <= id_Rt;
      ex_Rd       <= id_Rd;
      ex_DstAlt   <= id_DstAlt;
      ex_RegDst   <= id_RegDst;
      ex_RegWrite <= id_RegWrite;
      ex_MemRead  <= id_MemRead;
      ex_Ctrl     <= id_Ctrl;
      ex_RsData   <= id_RsData;
      ex_RtData   <= id_RtData;
      ex_Imm      <= id_Imm;
    end
  end

  // Saturating bubble counter; only cleared by reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      BubbleCount <= '0;
    end else if (countBubble && (BubbleCount != {CNT_W{1'b1}})) begin
      BubbleCount <= BubbleCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  alt;
    logic        usesRt;
    logic [1:0]  regDst;
    logic        regWrite;
    logic        memRead;
    logic [11:0] ctrl;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
  } idIn_t;

  typedef struct {
    string      name;
    logic       flush;
    logic       ext;
    idIn_t      id;
    logic       expHaz;
    logic       expValid;
    logic [4:0] expRt;
    int         expCnt;
  } vec_t;

  logic        Clk;
  logic        Rst_n;
  logic        Flush;
  logic        ExtStall;
  idIn_t       id;
  logic        HazardStall;
  logic        ex_Valid;
  logic [4:0]  ex_Rs, ex_Rt, ex_Rd, ex_DstAlt;
  logic [1:0]  ex_RegDst;
  logic        ex_RegWrite, ex_MemRead;
  logic [11:0] ex_Ctrl;
  logic [31:0] ex_RsData, ex_RtData, ex_Imm;
  logic [15:0] BubbleCount;

  // Second instance with a narrow counter sharing all inputs, so saturation
  // is reachable in a few dozen cycles.
  logic        hazSmall;
  logic        vSmall;
  logic [4:0]  rsS, rtS, rdS, altS;
  logic [1:0]  rdstS;
  logic        rwS, mrS;
  logic [11:0] ctrlS;
  logic [31:0] rsdS, rtdS, immS;
  logic [3:0]  cntSmall;

  int nVec = 0;
  int nMis = 0;

  idIn_t mEx;
  int    mCnt;
  vec_t  tbl[$];

  id_ex_pipe_reg dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .ExtStall(ExtStall),
    .id_Valid(id.valid), .id_Rs(id.rs), .id_Rt(id.rt), .id_Rd(id.rd),
    .id_DstAlt(id.alt), .id_UsesRt(id.usesRt), .id_RegDst(id.regDst),
    .id_RegWrite(id.regWrite), .id_MemRead(id.memRead), .id_Ctrl(id.ctrl),
    .id_RsData(id.rsData), .id_RtData(id.rtData), .id_Imm(id.imm),
    .HazardStall(HazardStall), .ex_Valid(ex_Valid), .ex_Rs(ex_Rs),
    .ex_Rt(ex_Rt), .ex_Rd(ex_Rd), .ex_DstAlt(ex_DstAlt),
    .ex_RegDst(ex_RegDst), .ex_RegWrite(ex_RegWrite),
    .ex_MemRead(ex_MemRead), .ex_Ctrl(ex_Ctrl), .ex_RsData(ex_RsData),
    .ex_RtData(ex_RtData), .ex_Imm(ex_Imm), .BubbleCount(BubbleCount)
  );

  id_ex_pipe_reg #(.CNT_W(4)) dutSmall (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .ExtStall(ExtStall),
    .id_Valid(id.valid), .id_Rs(id.rs), .id_Rt(id.rt), .id_Rd(id.rd),
    .id_DstAlt(id.alt), .id_UsesRt(id.usesRt), .id_RegDst(id.regDst),
    .id_RegWrite(id.regWrite), .id_MemRead(id.memRead), .id_Ctrl(id.ctrl),
    .id_RsData(id.rsData), .id_RtData(id.rtData), .id_Imm(id.imm),
    .HazardStall(hazSmall), .ex_Valid(vSmall), .ex_Rs(rsS),
    .ex_Rt(rtS), .ex_Rd(rdS), .ex_DstAlt(altS),
    .ex_RegDst(rdstS), .ex_RegWrite(rwS),
    .ex_MemRead(mrS), .ex_Ctrl(ctrlS), .ex_RsData(rsdS),
    .ex_RtData(rtdS), .ex_Imm(immS), .BubbleCount(cntSmall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic idIn_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                               logic [1:0] rdst, logic uses, logic mr);
    idIn_t r;
    r.valid    = v;
    r.rs       = rs;
    r.rt       = rt;
    r.rd       = rd;
    r.alt      = 5'd20;
    r.usesRt   = uses;
    r.regDst   = rdst;
    r.regWrite = 1'b1;
    r.memRead  = mr;
    r.ctrl     = 12'hA50 | {7'd0, rt};
    r.rsData   = 32'h1000_0000 | {27'd0, rs};
    r.rtData   = 32'h2000_0000 | {27'd0, rt};
    r.imm      = 32'hFFFF_0000 | {27'd0, rd};
    return r;
  endfunction

  function automatic logic [4:0] rReg();
    logic [4:0] pick [4];
    int k;
    pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2; pick[3] = 5'd31;
    k = int'($urandom_range(0, 4));
    if (k == 4) return 5'($urandom_range(0, 31));
    return pick[k];
  endfunction

  function automatic idIn_t rndId();
    idIn_t r;
    r.valid    = ($urandom_range(0, 7) != 0);
    r.rs       = rReg();
    r.rt       = rReg();
    r.rd       = rReg();
    r.alt      = rReg();
    r.usesRt   = 1'($urandom_range(0, 1));
    r.regDst   = 2'($urandom_range(0, 3));
    r.regWrite = 1'($urandom_range(0, 1));
    r.memRead  = 1'($urandom_range(0, 1));
    r.ctrl     = 12'($urandom);
    r.rsData   = $urandom;
    r.rtData   = $urandom;
    r.imm      = $urandom;
    return r;
  endfunction

  // Reference: destination is a lookup into {rt, rd, 31, alt} by RegDst.
  function automatic logic [4:0] destOf(idIn_t e);
    logic [4:0] cand [4];
    cand[0] = e.rt; cand[1] = e.rd; cand[2] = 5'd31; cand[3] = e.alt;
    return cand[e.regDst];
  endfunction

  function automatic logic modelHaz(idIn_t e, idIn_t d, logic ext);
    logic [4:0] dst;
    dst = destOf(e);
    if (ext || !e.valid || !e.memRead || dst == 5'd0 || !d.valid) return 1'b0;
    return (dst == d.rs) || (d.usesRt && dst == d.rt);
  endfunction

  function automatic idIn_t dutState();
    idIn_t r;
    r.valid = ex_Valid; r.rs = ex_Rs; r.rt = ex_Rt; r.rd = ex_Rd;
    r.alt = ex_DstAlt; r.usesRt = 1'b0; r.regDst = ex_RegDst;
    r.regWrite = ex_RegWrite; r.memRead = ex_MemRead; r.ctrl = ex_Ctrl;
    r.rsData = ex_RsData; r.rtData = ex_RtData; r.imm = ex_Imm;
    return r;
  endfunction

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkState(string nm);
    idIn_t e;
    e = mEx;
    e.usesRt = 1'b0;
    chk({nm, ".ex"}, 160'(dutState()), 160'(e));
    chk({nm, ".cnt"}, 160'(BubbleCount), 160'((mCnt > 65535) ? 65535 : mCnt));
    chk({nm, ".cnt4"}, 160'(cntSmall), 160'((mCnt > 15) ? 15 : mCnt));
  endtask

  // One pipeline cycle: drive inputs, check HazardStall, step the model,
  // clock, then check registered state. Entered and left 1 time unit after
  // a rising edge.
  task automatic cycle(string nm, logic fl, logic ext, idIn_t v, output logic hazSeen);
    logic h;
    Flush = fl;
    ExtStall = ext;
    id = v;
    #1;
    h = modelHaz(mEx, v, ext);
    hazSeen = HazardStall;
    chk({nm, ".haz"}, 160'(HazardStall), 160'(h));
    if (fl) begin
      mEx = '0;
    end else if (!ext) begin
      if (h) begin
        mEx = '0;
        mCnt++;
      end else begin
        mEx = v;
      end
    end
    @(posedge Clk);
    #1;
    checkState(nm);
  endtask

  task automatic addV(string n, logic fl, logic ext, idIn_t v,
                      logic eh, logic ev, logic [4:0] ert, int ec);
    vec_t t;
    t.name = n; t.flush = fl; t.ext = ext; t.id = v;
    t.expHaz = eh; t.expValid = ev; t.expRt = ert; t.expCnt = ec;
    tbl.push_back(t);
  endtask

  initial begin
    logic hz;
    Rst_n = 1'b0;
    Flush = 1'b0;
    ExtStall = 1'b0;
    id = mk(1'b1, 5'd8, 5'd8, 5'd8, REGDST_RT, 1'b1, 1'b1);
    mEx = '0;
    mCnt = 0;
    repeat (2) @(posedge Clk);
    #1;
    checkState("reset");
    Rst_n = 1'b1;

    // name, flush, ext, id, expHaz(before edge), expValid, expRt, expCnt (after edge)
    addV("lw8",    0, 0, mk(1, 5'd1,  5'd8, 5'd0, REGDST_RT, 0, 1), 0, 1, 5'd8, 0);
    addV("useRs8", 0, 0, mk(1, 5'd8,  5'd2, 5'd3, REGDST_RD, 1, 0), 1, 0, 5'd0, 1);
    addV("addIn",  0, 0, mk(1, 5'd8,  5'd2, 5'd3, REGDST_RD, 1, 0), 0, 1, 5'd2, 1);
    addV("jalLd",  0, 0, mk(1, 5'd1,  5'd4, 5'd5, REGDST_RA, 0, 1), 0, 1, 5'd4, 1);
    addV("useRa",  0, 0, mk(1, 5'd31, 5'd1, 5'd2, REGDST_RD, 1, 0), 1, 0, 5'd0, 2);
    addV("ldR0",   0, 0, mk(1, 5'd1,  5'd0, 5'd0, REGDST_RT, 0, 1), 0, 1, 5'd0, 2);
    addV("useR0",  0, 0, mk(1, 5'd0,  5'd0, 5'd3, REGDST_RD, 1, 0), 0, 1, 5'd0, 2);
    addV("ld9",    0, 0, mk(1, 5'd1,  5'd9, 5'd0, REGDST_RT, 0, 1), 0, 1, 5'd9, 2);
    addV("noRt9",  0, 0, mk(1, 5'd1,  5'd9, 5'd4, REGDST_RD, 0, 0), 0, 1, 5'd9, 2);
    addV("ld7",    0, 0, mk(1, 5'd2,  5'd7, 5'd0, REGDST_RT, 0, 1), 0, 1, 5'd7, 2);
    for (int k = 0; k < 3; k++)
      addV("ext", 0, 1, mk(1, 5'd7, 5'(k + 10), 5'(k), REGDST_RD, 1, 0), 0, 1, 5'd7, 2);
    addV("extFl",  1, 1, mk(1, 5'd7,  5'd3, 5'd3, REGDST_RD, 1, 0), 0, 0, 5'd0, 2);
    addV("ld6",    0, 0, mk(1, 5'd1,  5'd6, 5'd0, REGDST_RT, 0, 1), 0, 1, 5'd6, 2);
    addV("flHaz",  1, 0, mk(1, 5'd6,  5'd2, 5'd3, REGDST_RD, 1, 0), 1, 0, 5'd0, 2);
    addV("idInv",  0, 0, mk(0, 5'd1, 5'd12, 5'd4, REGDST_RD, 1, 0), 0, 0, 5'd12, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].name, tbl[i].flush, tbl[i].ext, tbl[i].id, hz);
      chk({tbl[i].name, ".tHaz"}, 160'(hz), 160'(tbl[i].expHaz));
      chk({tbl[i].name, ".tValid"}, 160'(ex_Valid), 160'(tbl[i].expValid));
      chk({tbl[i].name, ".tRt"}, 160'(ex_Rt), 160'(tbl[i].expRt));
      chk({tbl[i].name, ".tCnt"}, 160'(BubbleCount), 160'(tbl[i].expCnt));
    end

    // Self-dependent load alternates capture / hazard: 20 more bubbles.
    for (int i = 0; i < 40; i++)
      cycle("sat", 0, 0, mk(1, 5'd8, 5'd8, 5'd0, REGDST_RT, 0, 1), hz);
    chk("sat.cnt16", 160'(BubbleCount), 160'(22));
    chk("sat.cnt4", 160'(cntSmall), 160'(4'hF));

    // Reset asserted mid-cycle during an external stall clears at once.
    cycle("pre", 0, 0, mk(1, 5'd3, 5'd4, 5'd5, REGDST_RD, 1, 0), hz);
    cycle("stall", 0, 1, mk(1, 5'd9, 5'd9, 5'd9, REGDST_RT, 1, 1), hz);
    #2;
    Rst_n = 1'b0;
    #1;
    mEx = '0;
    mCnt = 0;
    checkState("rstMid");
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    cycle("postRst", 0, 0, mk(1, 5'd2, 5'd5, 5'd6, REGDST_ALT, 1, 1), hz);
    chk("postRst.valid", 160'(ex_Valid), 160'(1));

    for (int i = 0; i < 400; i++)
      cycle("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), rndId(), hz);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
